// File: rtl/crc9_pkg.sv
// CRC-9 shared definitions.
// Used by both the serial checker and the LFSR generator so that the two
// ends of the link agree on one polynomial and one codeword layout.
//   DATA_W  message width
//   CRC_W   CRC width
//   CODE_W  codeword width {data, crc}
//   POLY    generator x^9+x^8+x^7+x+1, bit i = coefficient of x^i
package crc9_pkg;

  localparam int DATA_W = 10;
  localparam int CRC_W  = 9;
  localparam int CODE_W = DATA_W + CRC_W;

  localparam logic [CRC_W:0] POLY = 10'h383;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/crc9_lfsr_step.sv
// One-bit CRC-9 division step (combinational).
// Shifts the next message/codeword bit into the remainder register and
// folds the polynomial back in when the outgoing top bit is set.
//   s       current remainder
//   b       next input bit (MSB-first stream)
//   s_next  remainder after absorbing b
module crc9_lfsr_step
  import crc9_pkg::*;
(
  input  logic [CRC_W-1:0] s,
  input  logic             b,
  output logic [CRC_W-1:0] s_next
);

  // x^9 term is implicit: it is the bit shifted out of s[8].
  localparam logic [CRC_W-1:0] POLY_LOW = POLY[CRC_W-1:0];

  always_comb begin
    s_next = {s[CRC_W-2:0], b};
    if (s[CRC_W-1]) begin
      s_next = s_next ^ POLY_LOW;
    end
  end

endmodule

// File: rtl/crc9_checker.sv
// Serial CRC-9 checker for {data[9:0], crc[8:0]} codewords.
// A codeword is loaded on start and divided MSB-first, one bit per clock.
// After the 19th bit the remainder is published as the syndrome together
// with a pass flag; the data field is published as soon as it is loaded.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     load strobe, honoured in IDLE and DONE only
//   code_in   codeword, bit 18 first
//   busy      high while shifting
//   done      one-cycle pulse when results become valid
//   crc_ok    syndrome == 0
//   syndrome  remainder of code(x) mod POLY
//   data_out  data field of the last accepted codeword
//
// state | meaning
// IDLE  | waiting for start, results held
// SHIFT | dividing one codeword bit per cycle
// DONE  | results just updated, done pulse, start accepted again
module crc9_checker
  import crc9_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CODE_W-1:0] code_in,
  output logic              busy,
  output logic              done,
  output logic              crc_ok,
  output logic [CRC_W-1:0]  syndrome,
  output logic [DATA_W-1:0] data_out
);

  localparam logic [4:0] LAST_BIT = 5'(CODE_W - 1);

  state_t              state;
  logic [CODE_W-1:0]   shreg;
  logic [CRC_W-1:0]    s;
  logic [CRC_W-1:0]    s_next;
  logic [4:0]          count;

  crc9_lfsr_step u_step (
    .s      (s),
    .b      (shreg[CODE_W-1]),
    .s_next (s_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      s        <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      syndrome <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= SHIFT;
            shreg    <= code_in;
            s        <= '0;
            count    <= '0;
            busy     <= 1'b1;
            data_out <= code_in[CODE_W-1:CRC_W];
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          s     <= s_next;
          shreg <= shreg << 1;
          count <= count + 5'd1;
          // Last bit: publish s_next directly so results land with done.
          if (count == LAST_BIT) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            syndrome <= s_next;
            crc_ok   <= (s_next == '0);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc9_checker.sv
module tb_crc9_checker;

  localparam logic [9:0] TB_POLY = 10'h383;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [18:0] code_in;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic [8:0]  syndrome;
  logic [9:0]  data_out;

  int n_tests = 0;
  int n_fail  = 0;

  crc9_checker dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .code_in  (code_in),
    .busy     (busy),
    .done     (done),
    .crc_ok   (crc_ok),
    .syndrome (syndrome),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Polynomial long division over GF(2): remainder of v(x) mod TB_POLY.
  function automatic logic [8:0] poly_mod(input logic [18:0] v);
    logic [18:0] r;
    logic [18:0] p;
    r = v;
    p = 19'(TB_POLY);
    for (int i = 18; i >= 9; i--) begin
      if (r[i]) r = r ^ (p << (i - 9));
    end
    return r[8:0];
  endfunction

  function automatic logic [18:0] make_code(input logic [9:0] d);
    logic [18:0] m;
    m = {d, 9'h000};
    return {d, poly_mod(m)};
  endfunction

  // Runs one codeword from IDLE/DONE to its DONE cycle and checks results.
  // poke: raise start with a different codeword mid-shift (must be ignored).
  task automatic run_code(input logic [18:0] code, input bit poke, input bit exp_ok_in, input bit use_ok);
    int early_done;
    int busy_low;
    logic [8:0] exp_syn;
    exp_syn = poly_mod(code);
    early_done = 0;
    busy_low = 0;
    start = 1'b1;
    code_in = code;
    tick();
    start = 1'b0;
    check("data_out_at_start", 32'(data_out), 32'(code[18:9]));
    check("busy_after_start", 32'(busy), 32'd1);
    for (int k = 1; k <= 19; k++) begin
      if (poke && k == 5) begin
        start = 1'b1;
        code_in = ~code;
      end
      tick();
      start = 1'b0;
      code_in = code;
      if (k < 19) begin
        if (done) early_done++;
        if (!busy) busy_low++;
      end
    end
    check("done_early", 32'(early_done), 32'd0);
    check("busy_drop", 32'(busy_low), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    check("syndrome", 32'(syndrome), 32'(exp_syn));
    check("crc_ok", 32'(crc_ok), 32'(exp_syn == 9'h0));
    if (use_ok) check("crc_ok_vs_err", 32'(crc_ok), 32'(exp_ok_in));
    check("data_out", 32'(data_out), 32'(code[18:9]));
  endtask

  initial begin
    logic [18:0] code;
    logic [9:0]  d;
    int          bitpos;
    bit          err;
    int          mism;

    reset = 1'b1;
    start = 1'b0;
    code_in = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_crc_ok", 32'(crc_ok), 32'd0);
    check("rst_syndrome", 32'(syndrome), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);

    // Directed codewords from the known table.
    run_code(19'h0, 1'b0, 1'b1, 1'b1);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("syndrome_held", 32'(syndrome), 32'd0);
    run_code({10'h001, 9'h183}, 1'b0, 1'b1, 1'b1);
    check("known_001_syn", 32'(syndrome), 32'h000);
    run_code({10'h002, 9'h085}, 1'b1, 1'b1, 1'b1);
    run_code({10'h002, 9'h084}, 1'b0, 1'b0, 1'b1);
    check("flip_bit0_syn", 32'(syndrome), 32'h001);
    tick();
    check("idle_syn_hold", 32'(syndrome), 32'h001);
    check("idle_ok_hold", 32'(crc_ok), 32'd0);
    check("idle_data_hold", 32'(data_out), 32'h002);

    // Start held high: accepted at E0, then in each DONE cycle.
    start = 1'b1;
    code_in = {10'h002, 9'h085};
    mism = 0;
    for (int k = 0; k <= 40; k++) begin
      tick();
      if (done !== (k == 19 || k == 39)) mism++;
      if (busy !== !(k == 19 || k == 39)) mism++;
    end
    start = 1'b0;
    check("held_start_pattern", 32'(mism), 32'd0);
    for (int k = 0; k < 19; k++) tick();
    check("held_final_done", 32'(done), 32'd1);
    check("held_final_ok", 32'(crc_ok), 32'd1);
    tick();

    // Reset in the middle of a shift; start in the reset cycle is ignored.
    start = 1'b1;
    code_in = {10'h3ff, 9'h1aa};
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ok", 32'(crc_ok), 32'd0);
    check("midrst_syn", 32'(syndrome), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    tick();
    check("midrst_idle", 32'(busy), 32'd0);
    run_code({10'h001, 9'h183}, 1'b0, 1'b1, 1'b1);

    // Random codewords, single-bit error injected on roughly half.
    for (int n = 0; n < 1000; n++) begin
      d = 10'($urandom_range(0, 1023));
      code = make_code(d);
      err = ($urandom_range(0, 1) == 1);
      if (err) begin
        bitpos = $urandom_range(0, 18);
        code[bitpos] = ~code[bitpos];
      end
      run_code(code, ($urandom_range(0, 3) == 0), !err, 1'b1);
      if (err) check("err_syn_nonzero", 32'(syndrome != 9'h0), 32'd1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
